// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 framing.
// The line is double-synchronized, and each bit is sampled mid-bit from a per-state counter.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       rx_done_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} StateT;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} StateT;
`endif

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  StateT         r_state;
  StateT         w_nextState;
  logic [CW-1:0] r_count;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          r_donePre;
  logic          r_frameErrPre;
  logic          w_tick;
  logic          w_stopSample;
  logic          w_parErrRec;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // START waits half a bit to land mid start bit; every later sample is one full bit apart.
  always_comb begin
    w_tick       = (r_state == START) ? (r_count == HALF_TICK) : (r_count == LAST_TICK);
    w_stopSample = (r_state == STOP) && w_tick;
    w_nextState  = r_state;
    case (r_state)
      IDLE:    if (r_prev && !r_sync2) w_nextState = START;
      START:   if (w_tick) w_nextState = r_sync2 ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:    if (w_tick && (r_bitIdx == 3'd7)) w_nextState = PARITY;
      PARITY:  if (w_tick) w_nextState = STOP;
`else
      DATA:    if (w_tick && (r_bitIdx == 3'd7)) w_nextState = STOP;
`endif
      STOP:    if (w_tick) w_nextState = r_sync2 ? IDLE : BREAK;
      BREAK:   if (r_sync2) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
    end else begin
      r_state <= w_nextState;
      if ((w_nextState != r_state) || ((r_state == DATA) && w_tick)) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
      if (w_nextState != r_state) begin
        r_bitIdx <= '0;
      end else if ((r_state == DATA) && w_tick) begin
        r_bitIdx <= r_bitIdx + 3'd1;
      end
      if ((r_state == DATA) && w_tick) begin
        r_shift <= {r_sync2, r_shift[7:1]};
      end
    end
  end

  // Pulses leave one cycle after the stop sample, together with the data_o update.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_donePre     <= 1'b0;
      r_frameErrPre <= 1'b0;
      rx_done_o     <= 1'b0;
      frame_err_o   <= 1'b0;
      data_o        <= 8'h00;
    end else begin
      r_donePre     <= w_stopSample && r_sync2 && !w_parErrRec;
      r_frameErrPre <= w_stopSample && !r_sync2;
      rx_done_o     <= r_donePre;
      frame_err_o   <= r_frameErrPre;
      if (r_donePre) begin
        data_o <= r_shift;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_parErr;
  logic r_parityErrPre;

  // Even parity: the parity bit must equal the XOR of the eight data bits.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_parErr       <= 1'b0;
      r_parityErrPre <= 1'b0;
      parity_err_o   <= 1'b0;
    end else begin
      if (r_state == START) begin
        r_parErr <= 1'b0;
      end else if ((r_state == PARITY) && w_tick) begin
        r_parErr <= r_sync2 ^ (^r_shift);
      end
      r_parityErrPre <= w_stopSample && r_sync2 && r_parErr;
      parity_err_o   <= r_parityErrPre;
    end
  end

  assign w_parErrRec = r_parErr;
`else
  assign w_parErrRec  = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  assign busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames for uart_rx at CLKS_PER_BIT = 16.
// Expected results come from framing rules (stop bit, even parity, fixed latency).
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LATENCY = 2 + 1 + CPB / 2 + 9 * CPB + 1 + PAR * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_i = 1'b0;
  logic [7:0] data_o;
  logic       rx_done_o;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int frameStart = 0;
  int doneCount = 0;
  int frameErrCount = 0;
  int parityErrCount = 0;
  int protoViol = 0;
  int lastDoneCycle = 0;
  int lastFrameErrCycle = 0;
  logic       prevPulse = 1'b0;
  logic [7:0] lastDoneData = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .rx_done_o   (rx_done_o),
    .frame_err_o (frame_err_o),
    .parity_err_o(parity_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Pulse bookkeeping, sampled on the falling edge.
  always @(negedge clk) begin
    if ($countones({rx_done_o, frame_err_o, parity_err_o}) > 1) protoViol++;
    if (prevPulse && (rx_done_o || frame_err_o || parity_err_o)) protoViol++;
    prevPulse = rx_done_o | frame_err_o | parity_err_o;
    if (rx_done_o) begin
      doneCount++;
      lastDoneCycle = cycleCount;
      lastDoneData  = data_o;
    end
    if (frame_err_o) begin
      frameErrCount++;
      lastFrameErrCycle = cycleCount;
    end
    if (parity_err_o) parityErrCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Sends start, data LSB first, optional parity, then a stop level held stopLen cycles.
  task automatic applyStimulus(input logic [7:0] data, input logic parityBit,
                               input logic stopBit, input int stopLen);
    logic [10:0] bits;
    bits = (PAR != 0) ? {stopBit, parityBit, data, 1'b0} : {1'b0, stopBit, data, 1'b0};
    @(posedge clk); #1;
    frameStart = cycleCount;
    for (int i = 0; i < 9 + PAR; i++) begin
      rx_i = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_i = bits[9 + PAR];
    repeat (stopLen) @(posedge clk);
    #1;
    rx_i = 1'b1;
  endtask

  task automatic receiveAndCheck(input logic [7:0] d, input string tag);
    int doneBefore = doneCount;
    int ferrBefore = frameErrCount;
    int perrBefore = parityErrCount;
    applyStimulus(d, ^d, 1'b1, CPB);
    checkOutput({tag, "_done"}, 32'(doneCount), 32'(doneBefore + 1));
    checkOutput({tag, "_data"}, 32'(lastDoneData), 32'(d));
    checkOutput({tag, "_hold"}, 32'(data_o), 32'(d));
    checkOutput({tag, "_lat"}, 32'(lastDoneCycle - frameStart), 32'(LATENCY));
    checkOutput({tag, "_errs"}, 32'(frameErrCount + parityErrCount),
                32'(ferrBefore + perrBefore));
  endtask

  initial begin
    int doneRef;
    int ferrRef;
    int perrRef;
    int gap;
    logic [7:0] d;
    logic [7:0] held;

    $display("[TB] reset with line held low");
    rst_n = 1'b1;
    rx_i  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_data", 32'(data_o), 32'h00);
    checkOutput("rst_pulses", 32'({rx_done_o, frame_err_o, parity_err_o}), 32'h0);
    checkOutput("rst_busy", 32'(busy_o), 32'h0);
    rst_n = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("low_release_busy", 32'(busy_o), 32'h0);
    rx_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("low_release_busy2", 32'(busy_o), 32'h0);

    $display("[TB] single frame and back-to-back frames");
    receiveAndCheck(8'h01, "f01");
    receiveAndCheck(8'h10, "b2b_10");
    receiveAndCheck(8'hA5, "b2b_a5");

    $display("[TB] glitch on idle line");
    repeat (20) @(posedge clk);
    #1;
    doneRef = doneCount;
    ferrRef = frameErrCount;
    rx_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("glitch_busy_hi", 32'(busy_o), 32'h1);
    @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("glitch_busy_lo", 32'(busy_o), 32'h0);
    checkOutput("glitch_nopulse", 32'(doneCount + frameErrCount), 32'(doneRef + ferrRef));
    receiveAndCheck(8'h3C, "after_glitch");

    $display("[TB] frame error with line held low");
    held = data_o;
    doneRef = doneCount;
    ferrRef = frameErrCount;
    applyStimulus(8'h55, ^8'h55, 1'b0, 40);
    checkOutput("ferr_pulse", 32'(frameErrCount), 32'(ferrRef + 1));
    checkOutput("ferr_lat", 32'(lastFrameErrCycle - frameStart), 32'(LATENCY));
    checkOutput("ferr_nodone", 32'(doneCount), 32'(doneRef));
    checkOutput("ferr_data", 32'(data_o), 32'(held));
    checkOutput("break_busy", 32'(busy_o), 32'h1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("break_exit", 32'(busy_o), 32'h0);
    receiveAndCheck(8'h7E, "after_break");

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity checks");
    receiveAndCheck(8'h03, "par_ok_03");
    doneRef = doneCount;
    perrRef = parityErrCount;
    applyStimulus(8'h03, 1'b1, 1'b1, CPB);
    checkOutput("par_bad_03_perr", 32'(parityErrCount), 32'(perrRef + 1));
    checkOutput("par_bad_03_nodone", 32'(doneCount), 32'(doneRef));
    checkOutput("par_bad_03_data", 32'(data_o), 32'h03);
    receiveAndCheck(8'h5A, "par_ok_5a");
    perrRef = parityErrCount;
    applyStimulus(8'h03, 1'b1, 1'b1, CPB);
    checkOutput("par_bad_hold_perr", 32'(parityErrCount), 32'(perrRef + 1));
    checkOutput("par_bad_hold_data", 32'(data_o), 32'h5A);
`endif

    $display("[TB] reset during data bit 4");
    doneRef = doneCount;
    ferrRef = frameErrCount;
    perrRef = parityErrCount;
    fork
      applyStimulus(8'hFF, ^8'hFF, 1'b1, CPB);
      begin
        @(posedge clk);
        repeat (CPB * 5 + CPB / 2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrst_data", 32'(data_o), 32'h00);
        checkOutput("midrst_busy", 32'(busy_o), 32'h0);
        checkOutput("midrst_pulses", 32'({rx_done_o, frame_err_o, parity_err_o}), 32'h0);
        rst_n = 1'b0;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midrst_nopulse",
                32'(doneCount + frameErrCount + parityErrCount),
                32'(doneRef + ferrRef + perrRef));
    checkOutput("midrst_idle", 32'(busy_o), 32'h0);
    receiveAndCheck(8'h02, "after_rst");

    $display("[TB] randomized frames");
    for (int k = 0; k < 6; k++) begin
      gap = int'($urandom_range(0, 20));
      repeat (gap) @(posedge clk);
      d = 8'($urandom);
      receiveAndCheck(d, $sformatf("rand%0d", k));
    end

    repeat (20) @(posedge clk);
    #1;
    checkOutput("pulse_protocol", 32'(protoViol), 32'h0);
    checkOutput("total_frame_errs", 32'(frameErrCount), 32'h1);
    checkOutput("total_parity_errs", 32'(parityErrCount), 32'(2 * PAR));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-high (block held in reset while rst_n = 1).
REQ-004 The block SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-005 The block SHALL have port data_o  output  8  last correctly received byte.
REQ-006 The block SHALL have port rx_done_o  output  1  single-cycle pulse, data_o valid; drives the command FSM's rx_done_i.
REQ-007 The block SHALL have port frame_err_o  output  1  single-cycle pulse, stop bit sampled low.
REQ-008 The block SHALL have port parity_err_o  output  1  single-cycle pulse, parity mismatch (constant 0 when parity is compiled out).
REQ-009 The block SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-010 rx_i SHALL pass through a 2-flop synchronizer; a third registered copy (prev) SHALL provide edge detection; all flops reset to 0.
REQ-011 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
REQ-012 IDLE -> START on synchronized 1->0 transition (prev = 1, sync = 0); a line already low at reset release SHALL NOT start a frame.
REQ-013 Bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, cleared on every state change.
REQ-014 START: sample after CLKS_PER_BIT/2 (integer division) cycles; sample 1 -> IDLE (glitch, no output pulse); sample 0 -> DATA.
REQ-015 DATA: 8 samples, each CLKS_PER_BIT cycles after the previous; LSB first into shift register; after the 8th sample -> PARITY (macro) or STOP.
REQ-016 PARITY: one sample CLKS_PER_BIT cycles later; expected value = even parity (XOR of 8 data bits); mismatch recorded; -> STOP.
REQ-017 STOP: sample CLKS_PER_BIT cycles later (mid stop bit).
REQ-018 Stop = 1, no parity error: data_o <= shift register and rx_done_o = 1 for exactly one cycle, in the cycle after the stop sample; -> IDLE.
REQ-019 Stop = 0: frame_err_o pulses one cycle, rx_done_o and parity_err_o stay 0, data_o unchanged; -> BREAK. Frame error SHALL take precedence over parity error.
REQ-020 Stop = 1, parity error: parity_err_o pulses one cycle, rx_done_o stays 0, data_o unchanged; -> IDLE.
REQ-021 BREAK: wait for synchronized line = 1, then -> IDLE; no start detection while in BREAK.
REQ-022 rx_done_o, frame_err_o and parity_err_o SHALL be mutually exclusive, registered, and never high on two consecutive cycles.
REQ-023 data_o SHALL hold its value between rx_done_o pulses.
REQ-024 Latency from the rx_i falling edge of the start bit to the rx_done_o pulse SHALL be 2 (sync) + 1 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles without parity, plus CLKS_PER_BIT with parity.
REQ-025 Return to IDLE after a stop sample SHALL allow a start bit beginning CLKS_PER_BIT/2 cycles later (back-to-back frames) to be detected.

Reset
REQ-026 While rst_n = 1: state = IDLE, counters and shift register = 0, data_o = 8'h00, rx_done_o = frame_err_o = parity_err_o = busy_o = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, the next frame requires a fresh 1->0 edge.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: 8E1 framing, PARITY state present, parity_err_o functional.
REQ-029 Macro UART_RX_PARITY_EN undefined: 8N1 framing, no PARITY state or logic, parity_err_o tied 0.

Verification (CLKS_PER_BIT = 16)
REQ-030 8N1 frame 0x01 -> one rx_done_o pulse, data_o = 0x01, exactly 2+1+8+144+1 = 156 cycles after the start edge.
REQ-031 Three back-to-back frames 0x01, 0x10, 0xA5 -> three rx_done_o pulses, data_o sequence 0x01, 0x10, 0xA5, no errors.
REQ-032 Low glitch of 5 cycles on idle line -> no pulse, busy_o returns to 0, next frame 0x3C received correctly.
REQ-033 Frame 0x55 with stop bit forced 0 and line held low 40 cycles -> frame_err_o pulse, data_o unchanged, no start until the line returns high, following 0x7E received correctly.
REQ-034 UART_RX_PARITY_EN: 0x03 with parity bit 0 -> rx_done_o, data_o = 0x03; 0x03 with parity bit 1 -> parity_err_o only, data_o unchanged.
REQ-035 rst_n pulsed during DATA bit 4 of frame 0xFF -> outputs 0, no pulse; subsequent frame 0x02 received correctly.
